// File: rtl/mips_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
// Holds FSM states, opcode/funct values, ALU codes and aluop selectors.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTYPEEX,
        S_RTYPEWB,
        S_BEQEX,
        S_ADDIEX,
        S_ADDIWB
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

endpackage

// File: rtl/mips_aludec.sv
// ALU decoder: maps aluop and R-type funct onto the ALU control code.
// Unknown funct values fall back to add rather than flagging an error.
module mips_aludec
    import mips_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_controller.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing lw/sw/R-type/beq/addi
// plus the ALU decoder. Outputs decode from state, gated only by memready/zero.
module mips_controller
    import mips_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memready,
    output logic       memtoreg,
    output logic       regdst,
    output logic       iord,
    output logic       pcsrc,
    output logic       alusrca,
    output logic       irwrite,
    output logic       pcen,
    output logic       regwrite,
    output logic       memwrite,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [2:0] alucontrol,
    output logic       illegal
);

    state_t state, next;
    logic   pcwrite, branch;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= RESET_STATE;
        else        state <= next;
    end

    always_comb begin
        next     = S_FETCH;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        iord     = 1'b0;
        pcsrc    = 1'b0;
        alusrca  = 1'b0;
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        regwrite = 1'b0;
        memwrite = 1'b0;
        alusrcb  = SRCB_B;
        aluop    = ALUOP_ADD;
        illegal  = 1'b0;
        case (state)
            S_FETCH: begin
                alusrcb = SRCB_FOUR;
                irwrite = memready;
                pcwrite = memready;
                next    = memready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target is computed here so BEQEX only needs the compare.
                alusrcb = SRCB_IMMSH2;
                case (op)
                    OP_LW, OP_SW: next = S_MEMADR;
                    OP_RTYPE:     next = S_RTYPEEX;
                    OP_BEQ:       next = S_BEQEX;
                    OP_ADDI:      next = S_ADDIEX;
                    default: begin
                        next    = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                next    = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord = 1'b1;
                next = memready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                next     = memready ? S_FETCH : S_MEMWR;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                next    = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 1'b1;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                next    = S_ADDIWB;
            end
            S_ADDIWB: regwrite = 1'b1;
            default:  next = S_FETCH;
        endcase
    end

    assign pcen = pcwrite | (branch & zero);

    mips_aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_mips_controller.sv
// Directed bench for mips_controller: walks each instruction class cycle by
// cycle and compares the state plus the packed control word against hand values.
`timescale 1ns/1ps
module tb_mips_controller;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, memready;
    logic       memtoreg, regdst, iord, pcsrc, alusrca, irwrite, pcen, regwrite, memwrite;
    logic [1:0] alusrcb, aluop;
    logic [2:0] alucontrol;
    logic       illegal;

    int tests = 0;
    int fails = 0;

    mips_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
        .memtoreg(memtoreg), .regdst(regdst), .iord(iord), .pcsrc(pcsrc), .alusrca(alusrca),
        .irwrite(irwrite), .pcen(pcen), .regwrite(regwrite), .memwrite(memwrite),
        .alusrcb(alusrcb), .aluop(aluop), .alucontrol(alucontrol), .illegal(illegal)
    );

    always #10 clk = ~clk;

    logic [16:0] outs;
    assign outs = {memtoreg, regdst, iord, pcsrc, alusrca, irwrite, pcen, regwrite, memwrite,
                   alusrcb, aluop, illegal, alucontrol};

    function automatic logic [16:0] e(input logic mtr, rd, io, ps, asa, irw, pce, rw, mw,
                                      input logic [1:0] asb, aop, input logic ill,
                                      input logic [2:0] alu);
        return {mtr, rd, io, ps, asa, irw, pce, rw, mw, asb, aop, ill, alu};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Sample at the falling edge, then move to just after the next rising edge.
    task automatic cyc(input string tag, input state_t st, input logic [16:0] exp);
        @(negedge clk);
        chk({tag, ".st"}, 32'(dut.state), 32'(st));
        chk({tag, ".out"}, 32'(outs), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    logic [16:0] F1, F0, DEC, DECI, MADR, MRD, MWB, MWR, REXS, RWB, BEQ1, BEQ0, AEX, AWB;
    logic [5:0]  fn_tab [7];
    logic [2:0]  alu_tab[7];

    initial begin
        F1   = e(0,0,0,0,0,1,1,0,0,2'b01,2'b00,0,3'b010);
        F0   = e(0,0,0,0,0,0,0,0,0,2'b01,2'b00,0,3'b010);
        DEC  = e(0,0,0,0,0,0,0,0,0,2'b11,2'b00,0,3'b010);
        DECI = e(0,0,0,0,0,0,0,0,0,2'b11,2'b00,1,3'b010);
        MADR = e(0,0,0,0,1,0,0,0,0,2'b10,2'b00,0,3'b010);
        MRD  = e(0,0,1,0,0,0,0,0,0,2'b00,2'b00,0,3'b010);
        MWB  = e(1,0,0,0,0,0,0,1,0,2'b00,2'b00,0,3'b010);
        MWR  = e(0,0,1,0,0,0,0,0,1,2'b00,2'b00,0,3'b010);
        REXS = e(0,0,0,0,1,0,0,0,0,2'b00,2'b10,0,3'b111);
        RWB  = e(0,1,0,0,0,0,0,1,0,2'b00,2'b00,0,3'b010);
        BEQ1 = e(0,0,0,1,1,0,1,0,0,2'b00,2'b01,0,3'b110);
        BEQ0 = e(0,0,0,1,1,0,0,0,0,2'b00,2'b01,0,3'b110);
        AEX  = e(0,0,0,0,1,0,0,0,0,2'b10,2'b00,0,3'b010);
        AWB  = e(0,0,0,0,0,0,0,1,0,2'b00,2'b00,0,3'b010);
        fn_tab  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b111111};
        alu_tab = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111,    3'b010,    3'b010};

        reset = 1'b0; op = 6'b100011; funct = 6'b100000; zero = 1'b0; memready = 1'b1;
        #5;
        chk("rst.st", 32'(dut.state), 32'(S_FETCH));
        chk("rst.out", 32'(outs), 32'(F1));
        @(posedge clk); #1;
        reset = 1'b1;

        // lw, zero-wait memory
        op = 6'b100011;
        cyc("lw.f", S_FETCH, F1);
        cyc("lw.d", S_DECODE, DEC);
        cyc("lw.a", S_MEMADR, MADR);
        cyc("lw.r", S_MEMRD, MRD);
        cyc("lw.wb", S_MEMWB, MWB);

        // lw with one stall cycle in MEMRD
        cyc("lws.f", S_FETCH, F1);
        cyc("lws.d", S_DECODE, DEC);
        cyc("lws.a", S_MEMADR, MADR);
        memready = 1'b0;
        cyc("lws.r0", S_MEMRD, MRD);
        memready = 1'b1;
        cyc("lws.r1", S_MEMRD, MRD);
        cyc("lws.wb", S_MEMWB, MWB);

        // sw with memready low for two MEMWR cycles
        op = 6'b101011;
        cyc("sw.f", S_FETCH, F1);
        cyc("sw.d", S_DECODE, DEC);
        cyc("sw.a", S_MEMADR, MADR);
        memready = 1'b0;
        cyc("sw.w0", S_MEMWR, MWR);
        cyc("sw.w1", S_MEMWR, MWR);
        memready = 1'b1;
        cyc("sw.w2", S_MEMWR, MWR);

        // beq taken, then not taken; memready low outside FETCH must not matter
        op = 6'b000100;
        cyc("beqt.f", S_FETCH, F1);
        memready = 1'b0;
        cyc("beqt.d", S_DECODE, DEC);
        zero = 1'b1;
        cyc("beqt.x", S_BEQEX, BEQ1);
        zero = 1'b0; memready = 1'b1;
        cyc("beqn.f", S_FETCH, F1);
        cyc("beqn.d", S_DECODE, DEC);
        cyc("beqn.x", S_BEQEX, BEQ0);

        // R-type slt, plus a funct sweep while sitting in RTYPEEX
        op = 6'b000000; funct = 6'b101010;
        cyc("slt.f", S_FETCH, F1);
        cyc("slt.d", S_DECODE, DEC);
        for (int i = 0; i < 7; i++) begin
            funct = fn_tab[i];
            #1;
            chk($sformatf("aludec.%0d", i), 32'(alucontrol), 32'(alu_tab[i]));
        end
        funct = 6'b101010;
        cyc("slt.x", S_RTYPEEX, REXS);
        cyc("slt.wb", S_RTYPEWB, RWB);

        // addi
        op = 6'b001000;
        cyc("addi.f", S_FETCH, F1);
        cyc("addi.d", S_DECODE, DEC);
        cyc("addi.x", S_ADDIEX, AEX);
        cyc("addi.wb", S_ADDIWB, AWB);

        // illegal opcode, then FETCH stalled by memready
        op = 6'b111111;
        cyc("ill.f", S_FETCH, F1);
        cyc("ill.d", S_DECODE, DECI);
        memready = 1'b0;
        cyc("ill.f0", S_FETCH, F0);
        memready = 1'b1;
        op = 6'b000000;
        cyc("ill.f1", S_FETCH, F1);

        // async reset in the middle of RTYPEEX
        cyc("mrst.d", S_DECODE, DEC);
        #2;
        chk("mrst.pre", 32'(dut.state), 32'(S_RTYPEEX));
        reset = 1'b0;
        #1;
        chk("mrst.st", 32'(dut.state), 32'(S_FETCH));
        chk("mrst.out", 32'(outs), 32'(F1));
        @(posedge clk); #1;
        chk("mrst.hold", 32'(dut.state), 32'(S_FETCH));
        chk("mrst.wr", 32'({regwrite, memwrite}), 32'(0));
        reset = 1'b1;
        cyc("mrst.f", S_FETCH, F1);
        cyc("mrst.d2", S_DECODE, DEC);
        cyc("mrst.x", S_RTYPEEX, REXS);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
